// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button conditioning, IDLE/RUN/LAP/PAUSE FSM,
// and the gated centisecond tick that paces the mm:ss.cc datapath.
module stopwatch_ctrl #(
   parameter int DEB_CYCLES = 500000,
   parameter int TICK_DIV   = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_ss,
   input  logic       btn_lr,
   output logic       run,
   output logic       hold,
   output logic       clear,
   output logic       tick,
   output logic [1:0] state
);

   localparam int DW = $clog2(DEB_CYCLES);
   localparam int TW = $clog2(TICK_DIV);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      LAP   = 2'd2,
      PAUSE = 2'd3
   } state_t;

   state_t        st;
   logic [1:0]    btn_raw;
   logic [1:0]    press;
   logic          press_ss;
   logic          press_lr;
   logic [TW-1:0] div;
   logic          div_en;

   assign btn_raw  = {btn_lr, btn_ss};
   assign press_ss = press[0];
   assign press_lr = press[1];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_btn
         logic          s1;
         logic          s2;
         logic          deb;
         logic          deb_q;
         logic          press_q;
         logic [DW-1:0] cnt;

         // A level is accepted only after DEB_CYCLES consecutive disagreeing samples.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               s1      <= 1'b0;
               s2      <= 1'b0;
               deb     <= 1'b0;
               deb_q   <= 1'b0;
               press_q <= 1'b0;
               cnt     <= '0;
            end else begin
               s1      <= btn_raw[gi];
               s2      <= s1;
               deb_q   <= deb;
               press_q <= deb & ~deb_q;
               if (s2 == deb) begin
                  cnt <= '0;
               end else if (cnt == DW'(DEB_CYCLES - 1)) begin
                  deb <= s2;
                  cnt <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
         end

         assign press[gi] = press_q;
      end
   endgenerate

   // Start/stop wins over lap/reset; a discarded lr press is not remembered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st    <= IDLE;
         run   <= 1'b0;
         hold  <= 1'b0;
         clear <= 1'b0;
      end else begin
         clear <= 1'b0;
         case (st)
            IDLE: begin
               if (press_ss) begin
                  st  <= RUN;
                  run <= 1'b1;
               end else if (press_lr) begin
                  clear <= 1'b1;
               end
            end
            RUN: begin
               if (press_ss) begin
                  st  <= PAUSE;
                  run <= 1'b0;
               end else if (press_lr) begin
                  st   <= LAP;
                  hold <= 1'b1;
               end
            end
            LAP: begin
               if (press_ss) begin
                  st   <= PAUSE;
                  run  <= 1'b0;
                  hold <= 1'b0;
               end else if (press_lr) begin
                  st   <= RUN;
                  hold <= 1'b0;
               end
            end
            PAUSE: begin
               if (press_ss) begin
                  st  <= RUN;
                  run <= 1'b1;
               end else if (press_lr) begin
                  st    <= IDLE;
                  clear <= 1'b1;
               end
            end
            default: st <= IDLE;
         endcase
      end
   end

   assign state = st;

   // The edge that stops the watch does not advance the divider, so a tick
   // can never coincide with run falling; the held phase resumes on restart.
   assign div_en = run & ~press_ss;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div  <= '0;
         tick <= 1'b0;
      end else if (clear) begin
         div  <= '0;
         tick <= 1'b0;
      end else if (div_en) begin
         if (div == TW'(TICK_DIV - 1)) begin
            div  <= '0;
            tick <= 1'b1;
         end else begin
            div  <= div + 1'b1;
            tick <= 1'b0;
         end
      end else begin
         tick <= 1'b0;
      end
   end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DEB_CYCLES=4, TICK_DIV=5: a per-cycle
// vector table for the first press plus hand-written multi-cycle sequences.
module tb_stopwatch_ctrl;

   localparam int DEB  = 4;
   localparam int TDIV = 5;
   localparam int NVEC = 40;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_ss = 1'b0;
   logic       btn_lr = 1'b0;
   logic       run;
   logic       hold;
   logic       clear;
   logic       tick;
   logic [1:0] state;

   stopwatch_ctrl #(.DEB_CYCLES(DEB), .TICK_DIV(TDIV)) dut (
      .clk    (clk),
      .rst    (rst),
      .btn_ss (btn_ss),
      .btn_lr (btn_lr),
      .run    (run),
      .hold   (hold),
      .clear  (clear),
      .tick   (tick),
      .state  (state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       ss;
      logic       lr;
      logic       run;
      logic       hold;
      logic       clear;
      logic       tick;
      logic [1:0] state;
   } vec_t;

   vec_t tbl [NVEC];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int tick_count = 0;
   int clear_count = 0;
   int last_tick = -1;
   bit streak = 1'b0;
   logic prev_tick = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Continuous tick properties: one cycle wide, only while running, never
   // with clear, and exactly TDIV cycles apart while run stays high.
   always @(negedge clk) begin
      if (tick) begin
         tick_count++;
         chk("tick_width", int'(prev_tick), 0);
         chk("tick_run", int'(run), 1);
         chk("tick_clear", int'(clear), 0);
         if (streak) chk("tick_gap", cyc - last_tick, TDIV);
         last_tick = cyc;
         streak = 1'b1;
      end
      if (!run) streak = 1'b0;
      if (clear) clear_count++;
      prev_tick = tick;
   end

   task automatic chk_out(input string tag, input int r, input int h, input int c, input int s);
      chk({tag, ".run"}, int'(run), r);
      chk({tag, ".hold"}, int'(hold), h);
      chk({tag, ".clear"}, int'(clear), c);
      chk({tag, ".state"}, int'(state), s);
   endtask

   // Drive the buttons and stop right after the edge where the FSM reacts.
   task automatic push(input logic ss, input logic lr);
      btn_ss = ss;
      btn_lr = lr;
      repeat (DEB + 4) @(posedge clk);
      #1;
   endtask

   task automatic release_all();
      repeat (2) @(posedge clk);
      #1;
      btn_ss = 1'b0;
      btn_lr = 1'b0;
      repeat (14) @(posedge clk);
      #1;
   endtask

   task automatic wait_tick(output int at);
      at = -1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (tick) begin
            at = cyc;
            break;
         end
      end
   endtask

   initial begin
      int f_cyc;
      int r_cyc;
      int pdiv;
      int at;
      int tc;
      int cc;

      // Entry i is applied before edge i and checked just after it.
      for (int i = 0; i < NVEC; i++) begin
         tbl[i].ss    = (i < 3) || (i >= 10 && i < 20);
         tbl[i].lr    = 1'b0;
         tbl[i].run   = (i >= 17);
         tbl[i].hold  = 1'b0;
         tbl[i].clear = 1'b0;
         tbl[i].tick  = (i == 22) || (i == 27) || (i == 32) || (i == 37);
         tbl[i].state = (i >= 17) ? 2'd1 : 2'd0;
      end

      repeat (3) @(posedge clk);
      #3;
      chk_out("in_reset", 0, 0, 0, 0);
      chk("in_reset.tick", int'(tick), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk_out("after_reset", 0, 0, 0, 0);

      // Glitch of 3 cycles, then a real 10-cycle start press.
      for (int i = 0; i < NVEC; i++) begin
         btn_ss = tbl[i].ss;
         btn_lr = tbl[i].lr;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d.run", i), int'(run), int'(tbl[i].run));
         chk($sformatf("vec%0d.hold", i), int'(hold), int'(tbl[i].hold));
         chk($sformatf("vec%0d.clear", i), int'(clear), int'(tbl[i].clear));
         chk($sformatf("vec%0d.tick", i), int'(tick), int'(tbl[i].tick));
         chk($sformatf("vec%0d.state", i), int'(state), int'(tbl[i].state));
      end

      // RUN -> LAP -> PAUSE, then resume from the frozen divider phase.
      push(1'b0, 1'b1);
      chk_out("lap", 1, 1, 0, 2);
      release_all();
      push(1'b1, 1'b0);
      chk_out("pause", 0, 0, 0, 3);
      f_cyc = cyc;
      pdiv = f_cyc - 1 - last_tick;
      tc = tick_count;
      release_all();
      chk("pause.no_tick", tick_count - tc, 0);
      push(1'b1, 1'b0);
      chk_out("resume", 1, 0, 0, 1);
      r_cyc = cyc;
      wait_tick(at);
      chk("resume.first_tick", at, r_cyc + TDIV - pdiv);
      release_all();

      // 1000 uninterrupted RUN cycles.
      @(negedge clk);
      #1;
      tc = tick_count;
      repeat (1000) @(negedge clk);
      #1;
      chk("long.tick_count", tick_count - tc, 200);
      @(posedge clk);
      #1;

      // PAUSE -> lr clears to IDLE, lr again in IDLE clears again.
      push(1'b1, 1'b0);
      chk_out("pause2", 0, 0, 0, 3);
      release_all();
      push(1'b0, 1'b1);
      chk_out("clr1", 0, 0, 1, 0);
      @(posedge clk);
      #1;
      chk("clr1.one_cycle", int'(clear), 0);
      release_all();
      push(1'b0, 1'b1);
      chk_out("clr2", 0, 0, 1, 0);
      @(posedge clk);
      #1;
      chk("clr2.one_cycle", int'(clear), 0);
      release_all();
      push(1'b1, 1'b0);
      chk_out("restart", 1, 0, 0, 1);
      r_cyc = cyc;
      wait_tick(at);
      chk("restart.first_tick", at, r_cyc + TDIV);
      release_all();

      // Simultaneous press from IDLE; lr then held high.
      push(1'b1, 1'b0);
      release_all();
      push(1'b0, 1'b1);
      chk_out("to_idle", 0, 0, 1, 0);
      release_all();
      cc = clear_count;
      push(1'b1, 1'b1);
      chk_out("both", 1, 0, 0, 1);
      btn_ss = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      chk_out("lr_held", 1, 0, 0, 1);
      chk("lr_held.no_clear", clear_count - cc, 0);
      btn_lr = 1'b0;
      repeat (14) @(posedge clk);
      #1;

      // Asynchronous reset mid-RUN.
      chk("pre_rst.run", int'(run), 1);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk_out("async_rst", 0, 0, 0, 0);
      chk("async_rst.tick", int'(tick), 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      tc = tick_count;
      cc = clear_count;
      repeat (30) @(posedge clk);
      #1;
      chk_out("post_rst", 0, 0, 0, 0);
      chk("post_rst.no_tick", tick_count - tc, 0);
      chk("post_rst.no_clear", clear_count - cc, 0);

      // Start button held through reset release gives exactly one press.
      rst = 1'b1;
      btn_ss = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (DEB + 3) @(posedge clk);
      #1;
      chk("held_rst.early", int'(state), 0);
      @(posedge clk);
      #1;
      chk_out("held_rst", 1, 0, 0, 1);
      release_all();
      chk("held_rst.stays", int'(state), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
